// File: rtl/inv_key_expansion.sv
// Reverse AES-128 key schedule: loaded with the round-10 key, it emits round keys
// 10 down to 0 over a valid/ready handshake, computing one step every three cycles.
module inv_key_expansion (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] keyInput,
    output logic         busy,
    output logic [127:0] keyOutput,
    output logic [3:0]   keyRound,
    output logic         keyValid,
    input  logic         keyReady,
    output logic         done
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_OUT  = 3'd1,
        S_XOR  = 3'd2,
        S_SUB  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic [31:0]  rot_q, rot_d;
    logic [31:0]  sub_word;
    logic [31:0]  rcon_word;
    logic [31:0]  w0, w1, w2, w3;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // One shared S-box lane per byte of the rotated word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub_lane
            assign sub_word[gi*8 +: 8] = sbox(rot_q[gi*8 +: 8]);
        end
    endgenerate

    assign rcon_word = rcon(round_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            round_q <= '0;
            rot_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rot_q   <= rot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_OUT;
            S_OUT:   if (keyReady) state_d = (round_q == 4'd0) ? S_DONE : S_XOR;
            S_XOR:   state_d = S_SUB;
            S_SUB:   state_d = S_OUT;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // w0 stays in place during XOR so SUB can fold it into the new p0.
    always_comb begin
        key_d   = key_q;
        round_d = round_q;
        rot_d   = rot_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = keyInput;
                    round_d = 4'd10;
                end
            end
            S_XOR: begin
                key_d[95:0] = {w1 ^ w0, w2 ^ w1, w3 ^ w2};
                rot_d       = {w3[23:0] ^ w2[23:0], w3[31:24] ^ w2[31:24]};
            end
            S_SUB: begin
                key_d[127:96] = w0 ^ sub_word ^ rcon_word;
                round_d       = (round_q != 4'd0) ? round_q - 4'd1 : round_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        keyValid = (state_q == S_OUT);
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
    end

    assign keyOutput = key_q;
    assign keyRound  = round_q;

endmodule

// File: tb/tb_inv_key_expansion.sv
// Randomized and directed bench for inv_key_expansion against a word-array model of
// the AES-128 schedule run backwards (w[i-4] = w[i] ^ f(w[i-1])).
module tb_inv_key_expansion;
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] keyInput;
    logic         busy;
    logic [127:0] keyOutput;
    logic [3:0]   keyRound;
    logic         keyValid;
    logic         keyReady;
    logic         done;

    int n_total = 0;
    int n_pass  = 0;

    logic [127:0] mk [0:10];
    logic [127:0] obs_keys [0:10];

    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic [127:0] sbox_rows [0:15] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    inv_key_expansion dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .keyInput  (keyInput),
        .busy      (busy),
        .keyOutput (keyOutput),
        .keyRound  (keyRound),
        .keyValid  (keyValid),
        .keyReady  (keyReady),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] sbox_tb(input logic [7:0] x);
        logic [127:0] row;
        row = sbox_rows[x[7:4]];
        return row[8*(15 - int'(x[3:0])) +: 8];
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] x);
        logic [31:0] r;
        r = {x[23:0], x[31:24]};
        return {sbox_tb(r[31:24]), sbox_tb(r[23:16]), sbox_tb(r[15:8]), sbox_tb(r[7:0])};
    endfunction

    function automatic logic [7:0] rcon_tb(input int j);
        logic [7:0] rc;
        rc = 8'h01;
        for (int n = 1; n < j; n++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        return rc;
    endfunction

    task automatic build_model(input logic [127:0] k10);
        logic [31:0] w [0:43];
        logic [31:0] t;
        w[40] = k10[127:96]; w[41] = k10[95:64]; w[42] = k10[63:32]; w[43] = k10[31:0];
        for (int i = 43; i >= 4; i--) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_rot(t) ^ {rcon_tb(i / 4), 24'h000000};
            w[i-4] = w[i] ^ t;
        end
        for (int r = 0; r <= 10; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Caller has already issued start and ticked, so the bench sits in cycle 1.
    task automatic walk(input logic [127:0] k, input int stall_round, input int stall_len,
                        input bit rnd_start, input bit start_in_done);
        int  next_r;
        int  stall_left;
        int  seen;
        int  extra;
        int  exp_cyc;
        bit  last_hs;
        bit  finished;
        build_model(k);
        next_r     = 10;
        stall_left = stall_len;
        seen       = -1;
        last_hs    = 1'b0;
        finished   = 1'b0;
        extra      = (stall_round >= 0) ? stall_len : 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            start    = rnd_start ? 1'($urandom) : 1'b0;
            keyInput = {$urandom, $urandom, $urandom, $urandom};
            if (last_hs) begin
                chk("done_pulse", 128'(done), 128'(1));
                chk("done_cycle", 128'(cyc), 128'(32 + extra));
                chk("busy_in_done", 128'(busy), 128'(1));
                chk("valid_in_done", 128'(keyValid), 128'(0));
                start = start_in_done;
                tick();
                start = 1'b0;
                chk("done_fall", 128'(done), 128'(0));
                chk("busy_fall", 128'(busy), 128'(0));
                chk("valid_idle", 128'(keyValid), 128'(0));
                finished = 1'b1;
                break;
            end
            chk("busy_walk", 128'(busy), 128'(1));
            if (keyValid === 1'b1) begin
                if (seen != next_r) begin
                    exp_cyc = 1 + 3 * (10 - next_r) + ((stall_round > next_r) ? stall_len : 0);
                    chk("first_cycle", 128'(cyc), 128'(exp_cyc));
                    seen = next_r;
                end
                chk("key_round", 128'(keyRound), 128'(next_r));
                chk("key_value", keyOutput, mk[next_r]);
                obs_keys[next_r] = keyOutput;
                if (next_r == stall_round && stall_left > 0) begin
                    keyReady = 1'b0;
                    stall_left--;
                end else begin
                    keyReady = 1'b1;
                    if (next_r == 0) last_hs = 1'b1;
                    else next_r--;
                end
            end else begin
                keyReady = 1'($urandom);
            end
            $display("cycle %0d: valid=%0b round=%0d key=%h ready=%0b", cyc, keyValid,
                     keyRound, keyOutput, keyReady);
            tick();
        end
        if (!finished) chk("walk_timeout", 128'(0), 128'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_key"}, keyOutput, 128'(0));
        chk({tag, "_round"}, 128'(keyRound), 128'(0));
        chk({tag, "_valid"}, 128'(keyValid), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
    endtask

    initial begin
        logic [127:0] rk;
        int           sr;
        int           sl;

        // Reset with start held high: reset must win.
        reset = 1'b1; start = 1'b1; keyInput = FIPS_K10; keyReady = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0; start = 1'b0;
        tick();
        chk("idle_valid", 128'(keyValid), 128'(0));
        chk("idle_busy", 128'(busy), 128'(0));

        // FIPS vector with stray starts during the walk and one in the DONE cycle.
        start = 1'b1; keyInput = FIPS_K10;
        tick();
        start = 1'b0;
        walk(FIPS_K10, -1, 0, 1'b1, 1'b1);
        chk("fips_r10", obs_keys[10], FIPS_K10);
        chk("fips_r9", obs_keys[9], 128'hac7766f319fadc2128d12941575c006e);
        chk("fips_r1", obs_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_r0", obs_keys[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Back-to-back: start in the first IDLE cycle, 5-cycle stall on round 9.
        start = 1'b1; keyInput = FIPS_K10;
        tick();
        start = 1'b0;
        walk(FIPS_K10, 9, 5, 1'b0, 1'b0);

        // Reset while round 5 is being computed.
        start = 1'b1; keyInput = FIPS_K10; keyReady = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 13; i++) tick();
        chk("pre_reset_valid", 128'(keyValid), 128'(1));
        chk("pre_reset_round", 128'(keyRound), 128'(6));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("midwalk");
        for (int i = 0; i < 4; i++) begin
            keyReady = 1'($urandom);
            tick();
            chk("post_reset_done", 128'(done), 128'(0));
            chk("post_reset_valid", 128'(keyValid), 128'(0));
        end
        start = 1'b1; keyInput = FIPS_K10;
        tick();
        start = 1'b0;
        walk(FIPS_K10, -1, 0, 1'b0, 1'b0);
        chk("refips_r0", obs_keys[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // All-zero round-10 key.
        start = 1'b1; keyInput = 128'h0;
        tick();
        start = 1'b0;
        walk(128'h0, -1, 0, 1'b1, 1'b0);

        // Random keys with random stall placement.
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(0, 2)) begin
                chk("gap_valid", 128'(keyValid), 128'(0));
                tick();
            end
            rk = {$urandom, $urandom, $urandom, $urandom};
            sr = int'($urandom_range(0, 10));
            sl = int'($urandom_range(0, 4));
            start = 1'b1; keyInput = rk;
            tick();
            start = 1'b0;
            walk(rk, sr, sl, 1'b1, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
